mul_seq_ctrl: RTL and testbench

Iterative multiply sequencer for the RV32M extension. It accepts one multiply request at a time from the execute stage and runs a radix-2 shift-add over sign-corrected magnitudes. It applies the final sign, returns the low or high word selected by `mulCode`, and signals completion with a one-cycle pulse. It replaces the single-cycle array multiplier on timing-constrained builds; the ALU drives `start` and stalls the pipeline on `busy`.

---
 rtl/mul_seq_ctrl.sv | 73 +++++++
 tb/tb_mul_seq_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative radix-2 shift-add multiplier for RV32M (MUL/MULH/MULHU/MULHSU).
// Define MUL_EARLY_EXIT_EN to leave CALC as soon as the remaining multiplier is zero.
module mul_seq_ctrl #(
   parameter int dataW = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [1:0]       mulCode,
   input  logic [dataW-1:0] A,
   input  logic [dataW-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [dataW-1:0] result
);
   localparam int CW = $clog2(dataW);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t state, state_nx;
   logic [2*dataW-1:0] mcand, prod, prod_fix;
   logic [dataW-1:0] mplier, a_mag, b_mag;
   logic [CW-1:0] cnt;
   logic [1:0] code;
   logic neg, a_neg, b_neg, last, accept;
   always_comb begin
      a_neg = mulCode != 2'd2 && A[dataW-1];
      b_neg = !mulCode[1] && B[dataW-1];
      a_mag = a_neg ? -A : A;
      b_mag = b_neg ? -B : B;
      accept = state == IDLE && start && !flush;
`ifdef MUL_EARLY_EXIT_EN
      last = cnt == CW'(dataW - 1) || mplier[dataW-1:1] == '0;
`else
      last = cnt == CW'(dataW - 1);
`endif
      prod_fix = neg ? -prod : prod;
      state_nx = flush ? IDLE :
                 state == IDLE ? (start ? CALC : IDLE) :
                 state == CALC ? (last ? FIX : CALC) :
                 state == FIX  ? DONE : IDLE;
      busy = state != IDLE;
      done = state == DONE;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
         cnt    <= '0;
         code   <= '0;
         neg    <= 1'b0;
         result <= '0;
      end else if (accept) begin
         mcand  <= {{dataW{1'b0}}, a_mag};
         mplier <= b_mag;
         prod   <= '0;
         cnt    <= '0;
         code   <= mulCode;
         neg    <= a_neg ^ b_neg;
      end else if (state == CALC && !flush) begin
         if (mplier[0]) prod <= prod + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end else if (state == FIX && !flush) begin
         // Sign fix and word select land together on the edge into DONE
         prod   <= prod_fix;
         result <= code == 2'd0 ? prod_fix[dataW-1:0] : prod_fix[2*dataW-1:dataW];
      end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: randomized + directed checks of mul_seq_ctrl against a countdown/arith model.
module tb_mul_seq_ctrl;
   logic clock = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
   logic [1:0] mulCode = '0;
   logic [31:0] A = '0, B = '0;
   logic busy, done;
   logic [31:0] result;
   int errors = 0, checks = 0;
   int rem = 0;
   logic [31:0] pend = '0, m_result = '0;
`ifdef MUL_EARLY_EXIT_EN
   localparam int IGN_AT = 1;
`else
   localparam int IGN_AT = 10;
`endif

   mul_seq_ctrl #(.dataW(32)) dut (
      .clock(clock), .reset(reset), .start(start), .flush(flush), .mulCode(mulCode),
      .A(A), .B(B), .busy(busy), .done(done), .result(result));

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Full-width product of the sign/zero-extended operands, then word select
   function automatic logic [31:0] ref_mul(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, p;
      sa = (c != 2'd2) ? {{32{a[31]}}, a} : {32'b0, a};
      sb = (c < 2'd2) ? {{32{b[31]}}, b} : {32'b0, b};
      p = sa * sb;
      return c == 2'd0 ? p[31:0] : p[63:32];
   endfunction

   function automatic int ref_iters(input logic [1:0] c, input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
      logic [31:0] mag;
      int n;
      mag = (c < 2'd2 && b[31]) ? -b : b;
      n = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
      return n;
`else
      return 32;
`endif
   endfunction

   function automatic int exp_lat(input logic [1:0] c, input logic [31:0] b);
      return ref_iters(c, b) + 1;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   // Model: rem counts edges until back in IDLE; done is the last cycle of it
   always @(posedge clock or posedge reset)
      if (reset) begin
         rem <= 0;
         m_result <= '0;
      end else if (flush) rem <= 0;
      else if (rem == 0) begin
         if (start) begin
            rem <= ref_iters(mulCode, B) + 2;
            pend <= ref_mul(mulCode, A, B);
         end
      end else begin
         rem <= rem - 1;
         if (rem == 2) m_result <= pend;
      end

   always @(negedge clock)
      if (!reset) begin
         check("busy", busy, rem != 0);
         check("done", done, rem == 1);
         check("result", result, m_result);
      end

   task automatic run_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] res, output int k);
      @(negedge clock);
      mulCode = c; A = a; B = b; start = 1'b1;
      @(negedge clock);
      start = 1'b0; A = $urandom; B = $urandom; mulCode = 2'($urandom);
      k = 0;
      do begin
         @(negedge clock);
         k++;
      end while (!done && k < 100);
      check("latency", k, lat);
      check("op_result", result, res);
      @(negedge clock);
      check("done_pulse_end", done, 1'b0);
   endtask

   initial begin
      int k, dones;
      repeat (2) @(negedge clock);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_result", result, 32'h0);
      reset = 1'b0;
      check("model_mul", ref_mul(2'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
      check("model_mulh", ref_mul(2'd1, 32'h80000000, 32'h80000000), 32'h40000000);
      check("model_mulhu", ref_mul(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
      check("model_mulhsu", ref_mul(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);

      run_op(2'd0, 32'd7, 32'hFFFFFFFD, exp_lat(2'd0, 32'hFFFFFFFD), 32'hFFFFFFEB, k);
`ifndef MUL_EARLY_EXIT_EN
      check("fixed_latency", k, 33);
`endif
      run_op(2'd1, 32'h80000000, 32'h80000000, exp_lat(2'd1, 32'h80000000), 32'h40000000, k);
      run_op(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, exp_lat(2'd2, 32'hFFFFFFFF), 32'hFFFFFFFE, k);
      run_op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, exp_lat(2'd3, 32'hFFFFFFFF), 32'hFFFFFFFF, k);
      run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, exp_lat(2'd0, 32'hFFFFFFFF), 32'h00000001, k);
`ifdef MUL_EARLY_EXIT_EN
      run_op(2'd0, 32'h12345678, 32'h1, 2, 32'h12345678, k);
      run_op(2'd0, 32'd5, 32'h80000000, 33, 32'h80000000, k);
`endif

      // Start while busy is dropped, not queued
      @(negedge clock);
      mulCode = 2'd0; A = 32'd3; B = 32'd5; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      dones = 0;
      for (int i = 1; i <= 60; i++) begin
         if (i == IGN_AT) begin A = 32'd9; B = 32'd9; start = 1'b1; end
         @(negedge clock);
         start = 1'b0;
         if (done) dones++;
      end
      check("ignored_start_dones", dones, 1);
      check("ignored_start_result", result, 32'd15);
      run_op(2'd0, 32'd9, 32'd9, exp_lat(2'd0, 32'd9), 32'd81, k);

      // Flush mid-CALC
      @(negedge clock);
      mulCode = 2'd2; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (20) @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      check("flush_busy", busy, 1'b0);
      dones = 0;
      repeat (40) begin
         @(negedge clock);
         if (done) dones++;
      end
      check("flush_dones", dones, 0);
      check("flush_result", result, 32'd81);

      // Flush beats start in IDLE
      start = 1'b1; flush = 1'b1;
      @(negedge clock);
      start = 1'b0; flush = 1'b0;
      check("flush_start_busy", busy, 1'b0);

      // Async reset mid-CALC
      mulCode = 2'd0; A = 32'd7; B = 32'd3; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (5) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_result", result, 32'h0);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 2500; i++) begin
         @(negedge clock);
         start = $urandom_range(0, 3) == 0;
         flush = $urandom_range(0, 59) == 0;
         mulCode = 2'($urandom);
         A = pick();
         B = pick();
      end
      @(negedge clock);
      start = 1'b0; flush = 1'b0;
      repeat (40) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
